// File: rtl/weight_ram_pkg.sv
// Shared types and helpers for the multi-lane weight bank (state enum, init pattern, wrap add, parity).
// The optional WRAM_PARITY_EN build uses parity() from here.
package weight_ram_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      INIT = 1'b1
   } wram_state_e;

   // Bit b of the init word is b[0] ^ k[0]; bits at and above data_w are zero.
   function automatic logic [31:0] init_word(input int unsigned k, input int unsigned data_w);
      logic [31:0] w;
      w = '0;
      for (int unsigned b = 0; b < 32; b++) begin
         if (b < data_w) w[b] = b[0] ^ k[0];
      end
      return w;
   endfunction

   function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                            input int unsigned depth);
      int unsigned s;
      s = base + off;
      return (s >= depth) ? (s - depth) : s;
   endfunction

   function automatic logic parity(input logic [63:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/wram_init_seq.sv
// Init sequencer: walks rows of LANES words from address 0 and flags the last row.
module wram_init_seq
   import weight_ram_pkg::*;
#(
   parameter int DEPTH  = 60,
   parameter int LANES  = 10,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_active,
   output logic              o_we,
   output logic [ADDR_W:0]   o_base,
   output logic              o_done
);

   localparam int ROWS = (DEPTH + LANES - 1) / LANES;
   localparam int RW   = $clog2(ROWS + 1);

   logic [RW-1:0] r_row;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_row <= '0;
      end else if (i_start) begin
         r_row <= '0;
      end else if (i_active) begin
         r_row <= o_done ? '0 : r_row + RW'(1);
      end
   end

   assign o_we   = i_active;
   assign o_done = (r_row == RW'(ROWS - 1));
   assign o_base = (ADDR_W + 1)'(32'(r_row) * LANES);

endmodule

// File: rtl/weight_bank_ram.sv
// Multi-lane weight store: LANES words per request, modulo-DEPTH addressing, built-in init pattern loader.
// Define WRAM_PARITY_EN to add per-word even parity and the o_par_err read-check output.
module weight_bank_ram
   import weight_ram_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 60,
   parameter int LANES  = 10,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_init_req,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic                      i_req_we,
   input  logic [ADDR_W-1:0]         i_req_addr,
   input  logic [LANES*DATA_W-1:0]   i_d,
   output logic [LANES*DATA_W-1:0]   o_q,
   output logic                      o_rd_valid,
   output logic                      o_addr_err,
   output logic                      o_busy
`ifdef WRAM_PARITY_EN
   ,
   output logic                      o_par_err
`endif
);

`ifdef WRAM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int WORD_W = DATA_W + PAR_W;
   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

   function automatic logic [WORD_W-1:0] mk_word(input logic [DATA_W-1:0] v);
`ifdef WRAM_PARITY_EN
      return {parity(64'(v)), v};
`else
      return v;
`endif
   endfunction

   logic [WORD_W-1:0]       r_mem [DEPTH];
   wram_state_e             r_state;
   logic [LANES*DATA_W-1:0] r_q;
   logic                    r_rd_valid;
   logic                    r_addr_err;

   logic                    w_accept;
   logic                    w_addr_ok;
   logic                    w_rd;
   logic                    w_init_we;
   logic                    w_init_done;
   logic                    w_init_start;
   logic [ADDR_W:0]         w_init_base;
   logic [ADDR_W-1:0]       w_idx       [LANES];
   logic [WORD_W-1:0]       w_wdata     [LANES];
   logic [ADDR_W:0]         w_init_addr [LANES];
   logic [WORD_W-1:0]       w_init_data [LANES];

   assign o_req_ready  = (r_state == IDLE) && !i_init_req;
   assign w_accept     = i_req_valid && o_req_ready;
   assign w_addr_ok    = ({1'b0, i_req_addr} < LP_DEPTH);
   assign w_rd         = w_accept && !i_req_we && w_addr_ok;
   assign w_init_start = (r_state == IDLE) && i_init_req;
   assign o_busy       = (r_state == INIT);

   wram_init_seq #(
      .DEPTH  (DEPTH),
      .LANES  (LANES),
      .ADDR_W (ADDR_W)
   ) u_init_seq (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_start  (w_init_start),
      .i_active (o_busy),
      .o_we     (w_init_we),
      .o_base   (w_init_base),
      .o_done   (w_init_done)
   );

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         w_idx[i]       = ADDR_W'(wrap_add(32'(i_req_addr), i, DEPTH));
         w_wdata[i]     = mk_word(i_d[i*DATA_W +: DATA_W]);
         w_init_addr[i] = w_init_base + (ADDR_W + 1)'(i);
         w_init_data[i] = mk_word(DATA_W'(init_word(32'(w_init_addr[i]), DATA_W)));
      end
   end

   // Init rows are clipped at the top of the array rather than wrapped.
   always_ff @(posedge i_clk) begin
      if (w_init_we) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (w_init_addr[i] < LP_DEPTH) r_mem[w_init_addr[i][ADDR_W-1:0]] <= w_init_data[i];
         end
      end else if (w_accept && i_req_we && w_addr_ok) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            r_mem[w_idx[i]] <= w_wdata[i];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= INIT;
         r_q        <= '0;
         r_rd_valid <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         r_rd_valid <= w_rd;
         r_addr_err <= w_accept && !w_addr_ok;
         if (w_rd) begin
            for (int unsigned i = 0; i < LANES; i++) begin
               r_q[i*DATA_W +: DATA_W] <= r_mem[w_idx[i]][DATA_W-1:0];
            end
         end
         if (r_state == IDLE) begin
            if (i_init_req) r_state <= INIT;
         end else if (w_init_done) begin
            r_state <= IDLE;
         end
      end
   end

   assign o_q        = r_q;
   assign o_rd_valid = r_rd_valid;
   assign o_addr_err = r_addr_err;

`ifdef WRAM_PARITY_EN
   logic r_par_err;
   logic w_par_mis;

   always_comb begin
      w_par_mis = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_par_mis = w_par_mis | parity(64'(r_mem[w_idx[i]]));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_par_err <= 1'b0;
      else       r_par_err <= w_rd && w_par_mis;
   end

   assign o_par_err = r_par_err;
`endif

endmodule

// File: tb/tb_weight_bank_ram.sv
// Directed + randomized bench for weight_bank_ram against an array-based reference model.
module tb_weight_bank_ram;

   localparam int DW    = 10;
   localparam int DEPTH = 60;
   localparam int LANES = 10;
   localparam int AW    = 6;
   localparam int QW    = LANES * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_req = 1'b0;
   logic          valid = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [QW-1:0] d = '0;
   logic          ready, rd_valid, addr_err, busy;
   logic [QW-1:0] q;
`ifdef WRAM_PARITY_EN
   logic          par_err;
`endif

   weight_bank_ram #(
      .DATA_W (DW),
      .DEPTH  (DEPTH),
      .LANES  (LANES),
      .ADDR_W (AW)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_init_req  (init_req),
      .i_req_valid (valid),
      .o_req_ready (ready),
      .i_req_we    (we),
      .i_req_addr  (addr),
      .i_d         (d),
      .o_q         (q),
      .o_rd_valid  (rd_valid),
      .o_addr_err  (addr_err),
      .o_busy      (busy)
`ifdef WRAM_PARITY_EN
      ,
      .o_par_err   (par_err)
`endif
   );

   always #5 clk = ~clk;

   int unsigned   model [DEPTH];
   logic [QW-1:0] exp_q = '0;
   logic          exp_par = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      for (int k = 0; k < DEPTH; k++) model[k] = (k % 2 == 1) ? 32'h155 : 32'h2AA;
   endtask

   function automatic logic [QW-1:0] model_read(input int unsigned a);
      logic [QW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(model[(a + i) % DEPTH]);
      return r;
   endfunction

   // Called #1 after a rising edge; leaves time at #1 after the accepting edge.
   task automatic req(input logic w, input int unsigned a, input logic [QW-1:0] data);
      chk("req_ready", 128'(ready), 128'(1));
      valid = 1'b1;
      we    = w;
      addr  = AW'(a);
      d     = data;
      @(posedge clk);
      #1;
      valid = 1'b0;
      if (a < DEPTH) begin
         if (w) begin
            for (int i = 0; i < LANES; i++) model[(a + i) % DEPTH] = 32'(data[i*DW +: DW]);
         end else begin
            exp_q = model_read(a);
         end
      end
      chk("rd_valid", 128'(rd_valid), 128'(!w && a < DEPTH));
      chk("addr_err", 128'(addr_err), 128'(a >= DEPTH));
      chk("q", 128'(q), 128'(exp_q));
`ifdef WRAM_PARITY_EN
      chk("par_err", 128'(par_err), 128'(exp_par && !w && a < DEPTH));
`endif
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (!busy) break;
         chk("ready_in_init", 128'(ready), 128'(0));
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [QW-1:0] rand_data();
      logic [QW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom);
      return r;
   endfunction

   initial begin
      int            nb;
      logic [QW-1:0] seq;
      logic [QW-1:0] dw_tmp;

      // 1: reset state and init length
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_q", 128'(q), 128'(0));
      chk("rst_rd_valid", 128'(rd_valid), 128'(0));
      chk("rst_addr_err", 128'(addr_err), 128'(0));
      chk("rst_busy", 128'(busy), 128'(1));
      count_busy(nb);
      chk("busy_cycles_reset", 128'(nb), 128'(6));
      model_init();
      req(1'b0, 0, '0);

      // 2: write with wrap, read back
      for (int i = 0; i < LANES; i++) seq[i*DW +: DW] = DW'(i + 1);
      req(1'b1, 55, seq);
      req(1'b0, 55, '0);
      req(1'b0, 0, '0);

      // 3: out-of-range addresses
      req(1'b0, 60, '0);
      req(1'b1, 61, rand_data());
      req(1'b0, 63, '0);
      req(1'b0, 55, '0);

      // 4: InitReq beats a same-cycle write
      init_req = 1'b1;
      valid    = 1'b1;
      we       = 1'b1;
      addr     = AW'(7);
      d        = rand_data();
      #1;
      chk("ready_on_initreq", 128'(ready), 128'(0));
      @(posedge clk);
      #1;
      init_req = 1'b0;
      valid    = 1'b0;
      count_busy(nb);
      chk("busy_cycles_initreq", 128'(nb), 128'(6));
      model_init();
      req(1'b0, 0, '0);
      req(1'b0, 5, '0);

      // 5: write-then-read and back-to-back reads
      dw_tmp = rand_data();
      req(1'b1, 3, dw_tmp);
      req(1'b0, 3, '0);
      req(1'b0, 10, '0);
      req(1'b0, 50, '0);

      // randomized traffic, including bad addresses
      for (int n = 0; n < 60; n++) begin
         req(1'($urandom_range(0, 1)), $urandom_range(0, 63), rand_data());
      end

      // 6: reset during INIT row 3
      init_req = 1'b1;
      @(posedge clk);
      #1;
      init_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      exp_q = '0;
      chk("midinit_rst_busy", 128'(busy), 128'(1));
      chk("midinit_rst_q", 128'(q), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      count_busy(nb);
      chk("busy_cycles_midinit", 128'(nb), 128'(6));
      model_init();
      req(1'b0, 0, '0);
      req(1'b0, 50, '0);

`ifdef WRAM_PARITY_EN
      dut.r_mem[5][DW] = ~dut.r_mem[5][DW];
      exp_par = 1'b1;
      req(1'b0, 0, '0);
      exp_par = 1'b0;
      req(1'b0, 10, '0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule
